// File: rtl/conv_window_sequencer.sv
// Front-end sequencer for the 2-D convolution engine: rate divider, window origin walker, filter store.
// Optional macro FILTER_LOAD_EN adds a runtime write port for the weights and bias.
module conv_window_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_C        = 5,
  parameter int unsigned N_R        = 3,
  parameter int unsigned COL_FIL    = 2,
  parameter int unsigned ROW_FIL    = 2,
  parameter int unsigned DIV        = 5,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned POS_W      = 4,
  parameter logic signed [DATA_WIDTH-1:0] W0    = DATA_WIDTH'(1),
  parameter logic signed [DATA_WIDTH-1:0] W1    = DATA_WIDTH'(2),
  parameter logic signed [DATA_WIDTH-1:0] W2    = DATA_WIDTH'(3),
  parameter logic signed [DATA_WIDTH-1:0] W3    = DATA_WIDTH'(4),
  parameter logic signed [DATA_WIDTH-1:0] BIAS0 = DATA_WIDTH'(0)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  tick,
  output logic                  clk_div,
  output logic [IDX_W-1:0]      row_i,
  output logic [IDX_W-1:0]      col_j,
  output logic [POS_W-1:0]      pos,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] rdata3,
  output logic [DATA_WIDTH-1:0] bias
`ifdef FILTER_LOAD_EN
  ,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
`endif
);

  localparam int unsigned DIV_W   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned COL_MAX = N_C - COL_FIL;
  localparam int unsigned ROW_MAX = N_R - ROW_FIL;
  localparam int unsigned POS_MAX = (ROW_MAX + 1) * (COL_MAX + 1) - 1;

  // Reject geometries whose indices cannot be represented.
  if (DIV < 2) begin : g_bad_div
    $error("conv_window_sequencer: DIV must be at least 2");
  end
  if (N_C < COL_FIL || N_R < ROW_FIL) begin : g_bad_geom
    $error("conv_window_sequencer: filter larger than image");
  end
  if ((COL_MAX >> IDX_W) != 0 || (ROW_MAX >> IDX_W) != 0) begin : g_bad_idx
    $error("conv_window_sequencer: IDX_W too narrow");
  end
  if ((POS_MAX >> POS_W) != 0) begin : g_bad_pos
    $error("conv_window_sequencer: POS_W too narrow");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             advance;
  logic             last_col;
  logic             last_row;

  // Free-running divider; tick and clk_div decode straight from the count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick    = (div_cnt == DIV_W'(DIV - 1));
  assign clk_div = (div_cnt < DIV_W'(DIV / 2));

  assign advance  = tick & en;
  assign last_col = (col_j == IDX_W'(COL_MAX));
  assign last_row = (row_i == IDX_W'(ROW_MAX));

  // Row-major scan: the linear index simply increments, so pos tracks the formula without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_i <= '0;
      col_j <= '0;
      pos   <= '0;
      done  <= 1'b0;
    end else begin
      done <= advance & last_col & last_row;
      if (advance) begin
        if (!last_col) begin
          col_j <= col_j + IDX_W'(1);
          pos   <= pos + POS_W'(1);
        end else begin
          col_j <= '0;
          if (last_row) begin
            row_i <= '0;
            pos   <= '0;
          end else begin
            row_i <= row_i + IDX_W'(1);
            pos   <= pos + POS_W'(1);
          end
        end
      end
    end
  end

`ifdef FILTER_LOAD_EN
  logic [DATA_WIDTH-1:0] w_q [4];
  logic [DATA_WIDTH-1:0] bias_q;

  // Writable filter store; addresses 5..7 are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q[0] <= W0;
      w_q[1] <= W1;
      w_q[2] <= W2;
      w_q[3] <= W3;
      bias_q <= BIAS0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    w_q[0] <= wr_data;
        3'd1:    w_q[1] <= wr_data;
        3'd2:    w_q[2] <= wr_data;
        3'd3:    w_q[3] <= wr_data;
        3'd4:    bias_q <= wr_data;
        default: ;
      endcase
    end
  end

  assign rdata0 = w_q[0];
  assign rdata1 = w_q[1];
  assign rdata2 = w_q[2];
  assign rdata3 = w_q[3];
  assign bias   = bias_q;
`else
  assign rdata0 = W0;
  assign rdata1 = W1;
  assign rdata2 = W2;
  assign rdata3 = W3;
  assign bias   = BIAS0;
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: divider, full scan, hold, mid-scan reset, filter store.
module tb_conv_window_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          tick, clk_div, done;
  logic [IW-1:0] row_i, col_j;
  logic [PW-1:0] pos;
  logic [DW-1:0] rdata0, rdata1, rdata2, rdata3, bias;
`ifdef FILTER_LOAD_EN
  logic          wr_en   = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
`endif

  conv_window_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .tick    (tick),
    .clk_div (clk_div),
    .row_i   (row_i),
    .col_j   (col_j),
    .pos     (pos),
    .done    (done),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .rdata3  (rdata3),
    .bias    (bias)
`ifdef FILTER_LOAD_EN
    ,
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       en;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] pos;
    logic       done;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hold rst for two edges; on return we sit mid-way through post-reset cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int found;

    tbl[0]  = '{cyc: 1,  en: 1'b1, row: 4'd0, col: 4'd0, pos: 4'd0, done: 1'b0};
    tbl[1]  = '{cyc: 5,  en: 1'b1, row: 4'd0, col: 4'd0, pos: 4'd0, done: 1'b0};
    tbl[2]  = '{cyc: 6,  en: 1'b1, row: 4'd0, col: 4'd1, pos: 4'd1, done: 1'b0};
    tbl[3]  = '{cyc: 11, en: 1'b1, row: 4'd0, col: 4'd2, pos: 4'd2, done: 1'b0};
    tbl[4]  = '{cyc: 16, en: 1'b1, row: 4'd0, col: 4'd3, pos: 4'd3, done: 1'b0};
    tbl[5]  = '{cyc: 21, en: 1'b1, row: 4'd1, col: 4'd0, pos: 4'd4, done: 1'b0};
    tbl[6]  = '{cyc: 26, en: 1'b1, row: 4'd1, col: 4'd1, pos: 4'd5, done: 1'b0};
    tbl[7]  = '{cyc: 31, en: 1'b1, row: 4'd1, col: 4'd2, pos: 4'd6, done: 1'b0};
    tbl[8]  = '{cyc: 36, en: 1'b1, row: 4'd1, col: 4'd3, pos: 4'd7, done: 1'b0};
    tbl[9]  = '{cyc: 40, en: 1'b1, row: 4'd1, col: 4'd3, pos: 4'd7, done: 1'b0};
    tbl[10] = '{cyc: 41, en: 1'b1, row: 4'd0, col: 4'd0, pos: 4'd0, done: 1'b1};
    tbl[11] = '{cyc: 42, en: 1'b1, row: 4'd0, col: 4'd0, pos: 4'd0, done: 1'b0};

    // Full scan with en high from release; divider pattern checked every cycle.
    en = 1'b1;
    do_reset();
    check("rst_rdata0", rdata0, 32'd1);
    check("rst_rdata1", rdata1, 32'd2);
    check("rst_rdata2", rdata2, 32'd3);
    check("rst_rdata3", rdata3, 32'd4);
    check("rst_bias",   bias,   32'd0);
    for (int c = 1; c <= 45; c++) begin
      cyc = c;
      check("tick",    tick,    32'((c % 5) == 0));
      check("clk_div", clk_div, 32'(((c - 1) % 5) < 2));
      foreach (tbl[k]) begin
        if (tbl[k].cyc == c) begin
          en = tbl[k].en;
          check("scan_row",  row_i, 32'(tbl[k].row));
          check("scan_col",  col_j, 32'(tbl[k].col));
          check("scan_pos",  pos,   32'(tbl[k].pos));
          check("scan_done", done,  32'(tbl[k].done));
        end
      end
      if (c < 45) @(negedge clk);
    end

    // Hold: drop en at pos=3 for three ticks, then resume.
    do_reset();
    goto_cycle(16);
    check("hold_pre_pos", pos, 32'd3);
    en = 1'b0;
    goto_cycle(31);
    check("hold_pos", pos, 32'd3);
    check("hold_col", col_j, 32'd3);
    check("hold_row", row_i, 32'd0);
    en = 1'b1;
    goto_cycle(35);
    check("resume_tick", tick, 32'd1);
    check("resume_pre_pos", pos, 32'd3);
    goto_cycle(36);
    check("resume_pos", pos, 32'd4);
    check("resume_row", row_i, 32'd1);
    check("resume_col", col_j, 32'd0);

    // Reset colliding with a tick at pos=5.
    do_reset();
    goto_cycle(30);
    check("midrst_pre_tick", tick, 32'd1);
    check("midrst_pre_pos", pos, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_row",  row_i, 32'd0);
    check("midrst_col",  col_j, 32'd0);
    check("midrst_pos",  pos,   32'd0);
    check("midrst_done", done,  32'd0);
    check("midrst_tick", tick,  32'd0);
    rst = 1'b0;
    cyc = 1;
    found = 0;
    for (int k = 1; k <= 20 && found == 0; k++) begin
      if (tick) found = k;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("midrst_first_tick", found, 32'd5);
    check("midrst_pos_at_tick", pos, 32'd0);

`ifdef FILTER_LOAD_EN
    // Runtime filter loads, ignored address, and write/reset collision.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFF0;
    @(negedge clk);
    check("load_rdata2", rdata2, 32'hFFF0);
    wr_addr = 3'd4; wr_data = 16'd7;
    @(negedge clk);
    check("load_bias", bias, 32'd7);
    wr_addr = 3'd6; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0;
    check("ign_rdata0", rdata0, 32'd1);
    check("ign_rdata1", rdata1, 32'd2);
    check("ign_rdata2", rdata2, 32'hFFF0);
    check("ign_rdata3", rdata3, 32'd4);
    check("ign_bias",   bias,   32'd7);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd9;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    check("coll_rdata0", rdata0, 32'd1);
    check("coll_rdata2", rdata2, 32'd3);
    check("coll_bias",   bias,   32'd0);
`else
    check("const_rdata2", rdata2, 32'd3);
    check("const_bias",   bias,   32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
